// File: rtl/spi_tx_feeder.sv
// Word FIFO that feeds SPI_slave one 32-bit word per CS_n frame, popping only after the frame ends.
// Optional statistics (overflow flag, underrun counter) are built when SPI_TXQ_STATS_EN is defined.
module spi_tx_feeder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     CS_n,
    output logic                     data_valid,
    output logic [DATA_W-1:0]        data_in,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
`ifdef SPI_TXQ_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic                     overflow,
    output logic [15:0]              underrun_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        BUSY
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_q;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   cs_s;
    logic                   cs_prev;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   wr_fire;
    logic                   load;
    logic                   pop;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign wr_ready = ~full;
    assign wr_fire  = wr_valid & ~full;
    assign level    = level_q;

    // Preset to 1 so that leaving reset never looks like a CS_n falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync <= '1;
            cs_prev <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], CS_n};
            cs_prev <= cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_fire, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The head stays in the FIFO until its frame completes, so a load never needs a pop.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && cs_s) begin
                    load    = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (cs_fall) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cs_rise) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_valid <= 1'b0;
            data_in    <= '0;
        end else begin
            data_valid <= load;
            if (load) begin
                data_in <= mem[rd_ptr];
            end
        end
    end

`ifdef SPI_TXQ_STATS_EN
    logic underrun_evt;

    assign underrun_evt = (state_q == IDLE) && cs_fall && empty;

    // Clear wins over a same-cycle event; the counter holds at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow     <= 1'b0;
            underrun_cnt <= '0;
        end else if (stats_clr) begin
            overflow     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
